// File: rtl/cmp_stream_pipe_if.sv
// Stream interface for cmp_stream_pipe: operand input channel, result output
// channel, counter clear and the three outcome tallies.
// master = operand source / result consumer / monitor, slave = the comparator.
interface cmp_stream_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             l;
  logic             clr;
  logic [CNT_W-1:0] g_cnt;
  logic [CNT_W-1:0] l_cnt;
  logic [CNT_W-1:0] eq_cnt;

  modport master (
    output in_valid, a, b, out_ready, clr,
    input  in_ready, out_valid, g, l, g_cnt, l_cnt, eq_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready, clr,
    output in_ready, out_valid, g, l, g_cnt, l_cnt, eq_cnt
  );
endinterface

// File: rtl/cmp_stream_pipe.sv
// cmp_stream_pipe: one-stage pipelined magnitude comparator with valid/ready
// flow control and saturating greater/less/equal tallies.
// Build option: define SIGNED_CMP_EN to compare a/b as two's complement;
// by default the operands are unsigned.
module cmp_stream_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  cmp_stream_pipe_if.slave bus
);

  // Result encoding {g,l}: 10 = a>b, 01 = a<b, 00 = a==b; 11 is never produced.
  function automatic logic [1:0] cmp_fn(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
`ifdef SIGNED_CMP_EN
    if ($signed(x) > $signed(y)) begin
      return 2'b10;
    end else if ($signed(x) < $signed(y)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
`else
    if (x > y) begin
      return 2'b10;
    end else if (x < y) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
`endif
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  logic             out_valid_q, out_valid_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic [CNT_W-1:0] g_cnt_q, g_cnt_d;
  logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic             in_ready;
  logic             accept;
  logic [1:0]       cmp_res;

  // The stage can take a new pair when it is empty or its result leaves now.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign cmp_res  = cmp_fn(bus.a, bus.b);

  // Next-state for the result stage and the outcome counters.
  always_comb begin
    out_valid_d = out_valid_q;
    g_d         = g_q;
    l_d         = l_q;
    g_cnt_d     = g_cnt_q;
    l_cnt_d     = l_cnt_q;
    eq_cnt_d    = eq_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      g_d         = cmp_res[1];
      l_d         = cmp_res[0];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Clear wins over counting a pair accepted in the same cycle.
    if (bus.clr) begin
      g_cnt_d  = {CNT_W{1'b0}};
      l_cnt_d  = {CNT_W{1'b0}};
      eq_cnt_d = {CNT_W{1'b0}};
    end else if (accept) begin
      case (cmp_res)
        2'b10:   g_cnt_d  = sat_inc(g_cnt_q);
        2'b01:   l_cnt_d  = sat_inc(l_cnt_q);
        2'b00:   eq_cnt_d = sat_inc(eq_cnt_q);
        default: eq_cnt_d = eq_cnt_q;
      endcase
    end else begin
      g_cnt_d  = g_cnt_q;
      l_cnt_d  = l_cnt_q;
      eq_cnt_d = eq_cnt_q;
    end
  end

  // State registers; reset drops any held result and zeroes the tallies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      g_cnt_q     <= {CNT_W{1'b0}};
      l_cnt_q     <= {CNT_W{1'b0}};
      eq_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      g_q         <= g_d;
      l_q         <= l_d;
      g_cnt_q     <= g_cnt_d;
      l_cnt_q     <= l_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.g         = g_q;
  assign bus.l         = l_q;
  assign bus.g_cnt     = g_cnt_q;
  assign bus.l_cnt     = l_cnt_q;
  assign bus.eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_cmp_stream_pipe.sv
// Directed self-checking bench for cmp_stream_pipe (WIDTH=8, CNT_W=4).
module tb_cmp_stream_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cmp_stream_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

  cmp_stream_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
  endtask

  task automatic chk_cnt(input string tag, input int ge, input int le, input int ee);
    chk({tag, ".g_cnt"},  bus.g_cnt,  ge);
    chk({tag, ".l_cnt"},  bus.l_cnt,  le);
    chk({tag, ".eq_cnt"}, bus.eq_cnt, ee);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0;
    bus.out_ready = 1'b1; bus.clr = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.g", bus.g, 0);
    chk("rst.l", bus.l, 0);
    chk_cnt("rst", 0, 0, 0);
    chk("rst.in_ready", bus.in_ready, 1);
    rst = 1'b0;
    tick();

    // Test 1: back-to-back pairs, full throughput
    drive(1'b1, 8'd5, 8'd5);
    tick();
    chk("t1.p0.out_valid", bus.out_valid, 1);
    chk("t1.p0.gl", {bus.g, bus.l}, 2'b00);
    drive(1'b1, 8'd9, 8'd3);
    tick();
    chk("t1.p1.out_valid", bus.out_valid, 1);
    chk("t1.p1.gl", {bus.g, bus.l}, 2'b10);
    drive(1'b1, 8'd3, 8'd9);
    tick();
    chk("t1.p2.out_valid", bus.out_valid, 1);
    chk("t1.p2.gl", {bus.g, bus.l}, 2'b01);
    chk_cnt("t1", 1, 1, 1);
    drive(1'b0, 8'd0, 8'd0);
    tick();
    chk("t1.drain.out_valid", bus.out_valid, 0);
    chk("t1.drain.gl_hold", {bus.g, bus.l}, 2'b01);

    // Test 2: unsigned vs signed interpretation of (200,100)
    drive(1'b1, 8'd200, 8'd100);
    tick();
`ifdef SIGNED_CMP_EN
    chk("t2.gl", {bus.g, bus.l}, 2'b01);
`else
    chk("t2.gl", {bus.g, bus.l}, 2'b10);
`endif
    drive(1'b0, 8'd0, 8'd0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk_cnt("t2.clr", 0, 0, 0);
    chk("t2.out_valid", bus.out_valid, 0);

    // Test 3: backpressure holds result and stalls the next pair
    drive(1'b1, 8'd1, 8'd2);
    tick();
    chk("t3.first.gl", {bus.g, bus.l}, 2'b01);
    drive(1'b1, 8'd7, 8'd0);
    bus.out_ready = 1'b0;
    #1;
    chk("t3.stall.in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.stall.out_valid", bus.out_valid, 1);
      chk("t3.stall.gl", {bus.g, bus.l}, 2'b01);
      chk("t3.stall.in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3.release.in_ready", bus.in_ready, 1);
    tick();
    chk("t3.next.out_valid", bus.out_valid, 1);
    chk("t3.next.gl", {bus.g, bus.l}, 2'b10);
    chk_cnt("t3", 1, 1, 0);
    drive(1'b0, 8'd0, 8'd0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;

    // Test 4: equal-counter saturation
    drive(1'b1, 8'd4, 8'd4);
    for (int i = 0; i < 14; i++) tick();
    chk_cnt("t4.n14", 0, 0, 14);
    tick();
    chk_cnt("t4.n15", 0, 0, 15);
    for (int i = 0; i < 5; i++) tick();
    chk_cnt("t4.n20", 0, 0, 15);
    chk("t4.gl", {bus.g, bus.l}, 2'b00);

    // Test 5: clr wins over counting, result still produced
    drive(1'b1, 8'd8, 8'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk_cnt("t5.clr", 0, 0, 0);
    chk("t5.out_valid", bus.out_valid, 1);
    chk("t5.gl", {bus.g, bus.l}, 2'b10);
    tick();
    chk_cnt("t5.resume", 1, 0, 0);

    // Test 6: asynchronous reset mid-operation
    drive(1'b0, 8'd0, 8'd0);
    bus.out_ready = 1'b0;
    tick();
    chk("t6.pre.out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6.rst.out_valid", bus.out_valid, 0);
    chk("t6.rst.g", bus.g, 0);
    chk("t6.rst.l", bus.l, 0);
    chk_cnt("t6.rst", 0, 0, 0);
    chk("t6.rst.in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'd2, 8'd9);
    tick();
    chk("t6.resume.out_valid", bus.out_valid, 1);
    chk("t6.resume.gl", {bus.g, bus.l}, 2'b01);
    chk_cnt("t6.resume", 0, 1, 0);
    drive(1'b0, 8'd0, 8'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
